// File: rtl/mem_store_buffer.sv
// Store buffer between the memory stage and a single-port bus: stores are queued and drained
// in order, and loads wait for the queue to empty before going out on the bus.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWriteM,
  input  logic                     MemReadM,
  input  logic [AW-1:0]            AddrM,
  input  logic [DW-1:0]            WriteDataM,
  output logic [DW-1:0]            ReadDataM,
  output logic                     StallM,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     bus_valid,
  output logic                     bus_we,
  output logic [AW-1:0]            bus_addr,
  output logic [DW-1:0]            bus_wdata,
  input  logic                     bus_ready,
  input  logic [DW-1:0]            bus_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t        state;
  logic [AW-1:0] addrq [DEPTH];
  logic [DW-1:0] dataq [DEPTH];
  logic [PW-1:0] wrptr;
  logic [PW-1:0] rdptr;
  logic [PW-1:0] rdnext;
  logic          full;
  logic          empty;
  logic          enq;
  logic          deq;

  assign full   = (Count == CNT_FULL);
  assign empty  = (Count == '0);
  assign enq    = MemWriteM & ~full;
  assign deq    = (state == WRITE) & bus_ready & ~empty;
  assign rdnext = rdptr + 1'b1;

  assign StallM = reset & ((MemWriteM & full) | (MemReadM & ~MemWriteM & (state != DONE)));

  always_ff @(posedge clk) begin
    if (enq) begin
      addrq[wrptr] <= AddrM;
      dataq[wrptr] <= WriteDataM;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrptr <= '0;
      rdptr <= '0;
      Count <= '0;
    end else begin
      if (enq) wrptr <= wrptr + 1'b1;
      if (deq) rdptr <= rdnext;
      if (enq && !deq)      Count <= Count + CNT_ONE;
      else if (deq && !enq) Count <= Count - CNT_ONE;
    end
  end

  // The bus request is registered, so the next head is looked up one cycle early; when the
  // queue is empty (or about to be), the entry being enqueued right now is that next head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      ReadDataM <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enq || !empty) begin
            state     <= WRITE;
            bus_valid <= 1'b1;
            bus_we    <= 1'b1;
            bus_addr  <= empty ? AddrM : addrq[rdptr];
            bus_wdata <= empty ? WriteDataM : dataq[rdptr];
          end else if (MemReadM && !MemWriteM) begin
            state     <= READ;
            bus_valid <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= AddrM;
          end
        end
        WRITE: begin
          if (bus_ready) begin
            if (Count != CNT_ONE || enq) begin
              bus_addr  <= (Count == CNT_ONE) ? AddrM : addrq[rdnext];
              bus_wdata <= (Count == CNT_ONE) ? WriteDataM : dataq[rdnext];
            end else begin
              state     <= IDLE;
              bus_valid <= 1'b0;
              bus_we    <= 1'b0;
            end
          end
        end
        READ: begin
          if (bus_ready) begin
            ReadDataM <= bus_rdata;
            state     <= DONE;
            bus_valid <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          bus_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
